// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Reads a burst of `length` consecutive words from a synchronous-read RAM,
//   starting at `base_addr`, and streams them out over a valid/ready interface.
//   A 3-entry output FIFO plus a single in-flight flag decouple the one-cycle
//   RAM read latency from downstream back-pressure.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   start      burst request, only sampled while idle
//   base_addr  first RAM address of the burst
//   length     number of words, 0..2**ADDR_WIDTH
//   ram_addr   RAM read address (held when no read is issued)
//   ram_q      RAM read data, valid the cycle after the address
//   out_data   stream data (FIFO head)
//   out_valid  stream data valid (FIFO not empty)
//   out_ready  downstream accept
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse when a burst completes
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; zero-length starts only pulse done
// RUN   | issuing reads while words remain and the FIFO has room
// FLUSH | all reads issued; draining in-flight read and FIFO
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  in_flight;
  logic                  zero_done;
  logic [DATA_WIDTH-1:0] fifo_mem [0:2];
  logic [1:0]            rd_idx, wr_idx, count;
  logic [2:0]            occ_sum;
  logic                  issue, push, pop, flush_done, start_ok;

  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Occupancy plus the word still coming back from the RAM must leave a free
  // slot, otherwise the read issued now could overflow the FIFO.
  assign occ_sum  = {1'b0, count} + {2'b00, in_flight};
  assign push     = in_flight;
  assign pop      = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) state_nxt = RUN;
      end
      RUN: begin
        issue = (remaining != '0) && (occ_sum <= 3'd2);
        if (issue && (remaining == CNT_ONE)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if ((count == 2'd0) && !in_flight) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      addr_q    <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      zero_done <= 1'b0;
      rd_idx    <= 2'd0;
      wr_idx    <= 2'd0;
      count     <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_mem[i] <= '0;
    end else begin
      zero_done <= start_ok && (length == '0);
      in_flight <= issue;

      if (start_ok) begin
        ptr       <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr_q    <= ptr;
        ptr       <= ptr + ADDR_ONE;
        remaining <= remaining - CNT_ONE;
      end

      if (push) begin
        fifo_mem[wr_idx] <= ram_q;
        wr_idx           <= idx_inc(wr_idx);
      end
      if (pop) rd_idx <= idx_inc(rd_idx);

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The RAM registers the address itself, so the issued address goes out
  // combinationally; between reads the last issued address is held.
  assign ram_addr  = issue ? ptr : addr_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_idx];
  assign busy      = (state != IDLE);
  assign done      = zero_done | flush_done;

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] ram_addr;
  logic [7:0] ram_q = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  logic [7:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .ram_addr(ram_addr), .ram_q(ram_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data for the address seen at an edge is
  // presented during the following cycle.
  always @(posedge clk) ram_q <= ram[ram_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // mode 0: always ready; mode 1: pattern 1,0,0 repeating; mode 2: random
  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc - 1) % 3) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  typedef struct {
    logic [7:0] base;
    int         len;
    int         mode;
    int         exp_first;  // cycle of first out_valid after the start edge, -1 none
    int         exp_done;   // done cycle, -1 means one cycle after the last pop
  } vec_t;

  // Called at a negedge; returns at a negedge.
  task automatic run_burst(input string tag, input logic [7:0] base, input int len,
                           input int mode, input int exp_first, input int exp_done);
    int exp_q[$];
    int first = -1, done_cyc = -1, done_cnt = 0, last_pop = -1;
    int busy_err = 0, stab_err = 0, ovf_err = 0, extra = 0, words = 0;
    int budget = len * 8 + 30;
    int want_done;
    logic prev_stall = 1'b0;
    logic exp_busy;
    logic [7:0] prev_data = '0;

    for (int k = 0; k < len; k++) exp_q.push_back(int'(ram[(int'(base) + k) % 256]));

    base_addr = base;
    length    = 9'(len);
    start     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      out_ready = ready_for(mode, cyc);
      exp_busy  = (len > 0) && (done_cyc < 0);
      if (busy !== exp_busy) busy_err++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
      if (dut.in_flight && dut.count == 2'd3) ovf_err++;
      if (out_valid && first < 0) first = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        words++;
        last_pop = cyc;
        if (exp_q.size() == 0) extra++;
        else chk({tag, " word"}, int'(out_data), exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end

    if (exp_done >= 0)  want_done = exp_done;
    else if (len == 0)  want_done = 1;
    else                want_done = last_pop + 1;

    chk({tag, " first_valid"}, first, exp_first);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_cycle"}, done_cyc, want_done);
    chk({tag, " word_count"}, words, len);
    chk({tag, " extra_words"}, extra, 0);
    chk({tag, " busy_errors"}, busy_err, 0);
    chk({tag, " stall_errors"}, stab_err, 0);
    chk({tag, " overflow"}, ovf_err, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int pops;
    int done_seen;
    int rlen;

    for (int i = 0; i < 256; i++) ram[i] = 8'(i);

    vecs[0] = '{8'h10, 4,   0, 3,  7};
    vecs[1] = '{8'hFE, 4,   0, 3,  7};
    vecs[2] = '{8'h00, 0,   0, -1, 1};
    vecs[3] = '{8'h00, 8,   1, 3,  -1};
    vecs[4] = '{8'h00, 256, 0, 3,  259};

    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ram_addr", int'(ram_addr), 0);
    chk("reset out_data", int'(out_data), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_burst($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode,
                vecs[v].exp_first, vecs[v].exp_done);

    // Reset in the middle of a length-10 burst, right after the 2nd word.
    base_addr = 8'h00;
    length    = 9'd10;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pops  = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (out_valid && out_ready) pops++;
      if (pops == 2) break;
      @(negedge clk);
    end
    chk("abort pops_before_reset", pops, 2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort ram_addr", int'(ram_addr), 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort no_done", done_seen, 0);
    reset = 1'b0;
    run_burst("after_abort", 8'h20, 2, 0, 3, 5);

    // Randomized bursts over random RAM contents.
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int b = 0; b < 12; b++) begin
      rlen = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 24));
      run_burst($sformatf("rand%0d", b), 8'($urandom), rlen, 2,
                (rlen == 0) ? -1 : 3, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 SHALL have `clk` as an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have `reset` as an input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have `start` as an input, 1 bit: burst request, sampled only in IDLE.
REQ-006 SHALL have `base_addr` as an input, ADDR_WIDTH bits: first RAM address of the burst.
REQ-007 SHALL have `length` as an input, ADDR_WIDTH+1 bits: word count, 0..2**ADDR_WIDTH.
REQ-008 SHALL have `ram_addr` as an output, ADDR_WIDTH bits: address to the RAM, which registers the address and presents its data on `ram_q` in the following cycle.
REQ-009 SHALL have `ram_q` as an input, DATA_WIDTH bits: RAM read data.
REQ-010 SHALL have `out_data` as an output, DATA_WIDTH bits: stream data.
REQ-011 SHALL have `out_valid` as an output, 1 bit: stream data valid.
REQ-012 SHALL have `out_ready` as an input, 1 bit: downstream accept.
REQ-013 SHALL have `busy` as an output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have `done` as an output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH.
- IDLE -> RUN on `start` with length != 0.
- RUN -> FLUSH after the last read is issued.
- FLUSH -> IDLE when the output buffer is empty and no read is in flight.
REQ-016 On `start` in IDLE, SHALL latch `base_addr` into a read pointer and `length` into a remaining-count register.
REQ-017 On `start` with length = 0, SHALL stay in IDLE, issue no reads, and pulse `done` in the next cycle.
REQ-018 SHALL ignore `start` while `busy` is high.
REQ-019 SHALL contain a 3-entry output FIFO and a 1-bit in-flight flag.
REQ-020 In RUN, SHALL issue a read in a cycle iff remaining != 0 and (FIFO occupancy + in-flight) <= 2, where occupancy is the value at the start of the cycle.
REQ-021 Issuing a read SHALL:
- drive `ram_addr` = pointer;
- set in-flight for the next cycle;
- increment the pointer modulo 2**ADDR_WIDTH, so 0xFF wraps to 0x00 for the default parameters;
- decrement remaining.
REQ-022 In any cycle with in-flight set, SHALL push `ram_q` into the FIFO at the end of that cycle.
REQ-023 When no read is issued, SHALL hold `ram_addr` at its last value; `ram_q` is then ignored.
REQ-024 SHALL drive `out_valid` = FIFO not empty and `out_data` = FIFO head; a pop occurs when `out_valid` && `out_ready`.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged with data order preserved.
REQ-026 The FIFO SHALL never overflow; the issue rule guarantees this. The bench shall flag any push while occupancy = 3.
REQ-027 With `out_ready` held high, SHALL sustain one word per cycle after the first.
REQ-028 The first `out_valid` SHALL occur in the 3rd cycle after the clock edge that samples `start`.
REQ-029 `done` SHALL pulse for exactly one cycle, in the cycle in which FLUSH returns to IDLE, i.e. the cycle after the last word is popped.
REQ-030 Data SHALL be emitted in address order, exactly `length` words per burst.
REQ-031 `out_valid`, once high, SHALL stay high with `out_data` stable until popped.

Reset
REQ-032 On `reset` high, asynchronously, SHALL force:
- state = IDLE;
- `busy` = 0, `done` = 0, `out_valid` = 0;
- `ram_addr` = 0, `out_data` = 0;
- FIFO empty, in-flight = 0, pointer = 0, remaining = 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst: no further reads and no `done` pulse. After release, the block SHALL accept a new `start` on the first edge.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- RAM[i] = i. Start with base 0x10, length 4, `out_ready` = 1 -> `out_data` 0x10, 0x11, 0x12, 0x13 on consecutive cycles, first valid 3 cycles after start; `done` one cycle after the last word.
- Base 0xFE, length 4 -> addresses 0xFE, 0xFF, 0x00, 0x01; data FE, FF, 00, 01.
- Length 0 -> no `out_valid`; `done` pulses the next cycle; `busy` stays 0.
- Base 0, length 8, `out_ready` toggling 1,0,0,1,... -> all 8 words in order, no loss or duplication, occupancy <= 3, `out_data` stable while stalled.
- Length 256 -> 256 words, `busy` high throughout, a single `done` pulse.
- Reset asserted after the 2nd word of a length-10 burst -> `out_valid`/`busy` drop immediately with no `done`; a following start with base 0x20, length 2 yields 0x20, 0x21.
